// File: rtl/cmos_xor_if.sv
// Operand/result bundle for cmos_xor: the bench drives x/y and observes the
// combinational, registered and counted results.
interface cmos_xor_if #(parameter int CNT_W = 8);
  logic             x;
  logic             y;
  logic             a;
  logic             a_n;
  logic             a_q;
  logic [CNT_W-1:0] ones_cnt;

  modport master (output x, y, input a, a_n, a_q, ones_cnt);
  modport slave  (input x, y, output a, a_n, a_q, ones_cnt);
endinterface

// File: rtl/cmos_xor.sv
// Switch-level static CMOS XOR with a registered copy of the result and a
// saturating count of the clock edges at which the result was high.
module cmos_xor #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  cmos_xor_if.slave  bus
);
  supply1 vdd;
  supply0 gnd;

  wire x_i = bus.x;
  wire y_i = bus.y;
  wire x_n, y_n;
  wire pu_0, pu_1, pd_0, pd_1;
  wire a_w, a_n_w;

  pmos inv_x_p (x_n, vdd, x_i);
  nmos inv_x_n (x_n, gnd, x_i);
  pmos inv_y_p (y_n, vdd, y_i);
  nmos inv_y_n (y_n, gnd, y_i);

  // Pull-up conducts for x!=y, pull-down for x==y; the two never overlap.
  pmos pu_a0 (pu_0, vdd, x_n);
  pmos pu_a1 (a_w,  pu_0, y_i);
  pmos pu_b0 (pu_1, vdd, x_i);
  pmos pu_b1 (a_w,  pu_1, y_n);

  nmos pd_a0 (pd_0, gnd, x_i);
  nmos pd_a1 (a_w,  pd_0, y_i);
  nmos pd_b0 (pd_1, gnd, x_n);
  nmos pd_b1 (a_w,  pd_1, y_n);

  pmos inv_a_p (a_n_w, vdd, a_w);
  nmos inv_a_n (a_n_w, gnd, a_w);

  assign bus.a   = a_w;
  assign bus.a_n = a_n_w;

  logic             a_q_q, a_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An X on a fails the equality test, so unknown inputs never bump the count.
  always_comb begin
    a_q_d = a_w;
    cnt_d = cnt_q;
    if (a_w == 1'b1 && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q_q <= a_q_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.a_q      = a_q_q;
  assign bus.ones_cnt = cnt_q;
endmodule

// File: tb/tb_cmos_xor.sv
// Directed checks of cmos_xor: truth table, registered path, saturation,
// asynchronous reset and mid-cycle input glitches.
module tb_cmos_xor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  cmos_xor_if #(.CNT_W(8)) bus8 ();
  cmos_xor_if #(.CNT_W(4)) bus4 ();

  cmos_xor #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  cmos_xor #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic set_xy(input logic xv, input logic yv);
    bus8.x = xv; bus8.y = yv;
    bus4.x = xv; bus4.y = yv;
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] tt_x;
    logic [3:0] tt_y;
    logic [3:0] tt_a;
    tt_x = 4'b1100;
    tt_y = 4'b1010;
    tt_a = 4'b0110;

    set_xy(1'b0, 1'b0);
    #1;
    chk("rst_aq8",  {31'd0, bus8.a_q}, 32'd0);
    chk("rst_cnt8", {24'd0, bus8.ones_cnt}, 32'd0);
    chk("rst_cnt4", {28'd0, bus4.ones_cnt}, 32'd0);

    // truth table with clock idle, vectors 00,01,10,11
    for (int i = 0; i < 4; i++) begin
      set_xy(tt_x[i], tt_y[i]);
      #1;
      chk($sformatf("tt_a_%0d", i),  {31'd0, bus8.a},   {31'd0, tt_a[i]});
      chk($sformatf("tt_an_%0d", i), {31'd0, bus8.a_n}, {31'd0, ~tt_a[i]});
      #9;
    end

    rst = 1'b0;
    set_xy(1'b1, 1'b0);
    tick();
    chk("reg_aq_e1",  {31'd0, bus8.a_q}, 32'd1);
    chk("reg_cnt_e1", {24'd0, bus8.ones_cnt}, 32'd1);
    tick();
    tick();
    chk("reg_cnt_e3", {24'd0, bus8.ones_cnt}, 32'd3);
    set_xy(1'b1, 1'b1);
    #1;
    chk("reg_a_11", {31'd0, bus8.a}, 32'd0);
    chk("reg_aq_pre", {31'd0, bus8.a_q}, 32'd1);
    tick();
    chk("reg_aq_11",  {31'd0, bus8.a_q}, 32'd0);
    chk("reg_cnt_11", {24'd0, bus8.ones_cnt}, 32'd3);

    set_xy(1'b1, 1'b0);
    tick();
    tick();
    chk("pre_rst_cnt", {24'd0, bus8.ones_cnt}, 32'd5);
    chk("pre_rst_aq",  {31'd0, bus8.a_q}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_aq",  {31'd0, bus8.a_q}, 32'd0);
    chk("arst_cnt", {24'd0, bus8.ones_cnt}, 32'd0);
    chk("arst_a",   {31'd0, bus8.a}, 32'd1);
    set_xy(1'b0, 1'b0);
    #1;
    chk("arst_a_00",  {31'd0, bus8.a},   32'd0);
    chk("arst_an_00", {31'd0, bus8.a_n}, 32'd1);
    set_xy(1'b1, 1'b0);
    tick();
    chk("arst_hold_cnt", {24'd0, bus8.ones_cnt}, 32'd0);
    chk("arst_hold_aq",  {31'd0, bus8.a_q}, 32'd0);

    #2 rst = 1'b0;
    tick();
    chk("rel_cnt", {24'd0, bus8.ones_cnt}, 32'd1);
    chk("rel_aq",  {31'd0, bus8.a_q}, 32'd1);

    set_xy(1'b0, 1'b0);
    tick();
    chk("gl_pre_aq", {31'd0, bus8.a_q}, 32'd0);
    #2 set_xy(1'b1, 1'b0);
    #1 chk("gl_a_hi", {31'd0, bus8.a}, 32'd1);
    chk("gl_an_lo", {31'd0, bus8.a_n}, 32'd0);
    set_xy(1'b0, 1'b0);
    #1 chk("gl_a_lo", {31'd0, bus8.a}, 32'd0);
    tick();
    chk("gl_aq",  {31'd0, bus8.a_q}, 32'd0);
    chk("gl_cnt", {24'd0, bus8.ones_cnt}, 32'd1);

    // saturation on the 4-bit counter, starting from a fresh reset
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    set_xy(1'b0, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("sat_e%0d", e), {28'd0, bus4.ones_cnt}, (e > 15) ? 32'd15 : e);
    end
    chk("sat_cnt8", {24'd0, bus8.ones_cnt}, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cmos_xor.md
CMOS_XOR -- requirements
Module: cmos_xor

Interface
REQ-001 Parameter CNT_W, default 8, width of the ones counter.
REQ-002 clk  input  1  single clock; all sequential state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 x  input  1  first operand.
REQ-005 y  input  1  second operand.
REQ-006 a  output  1  combinational XOR of x and y.
REQ-007 a_n  output  1  combinational complement of a.
REQ-008 a_q  output  1  registered copy of a.
REQ-009 ones_cnt  output  CNT_W  saturating count of rising edges at which a was 1.
REQ-010 The block has one clock and an asynchronous, active-high reset, with ports named clk and rst.

Function
REQ-011 a SHALL equal x XOR y at all times, independent of clk and rst, with zero cycles of latency.
  - 0,0 -> 0
  - 0,1 -> 1
  - 1,0 -> 1
  - 1,1 -> 0
REQ-012 a SHALL be built at switch level from pmos/nmos primitives between supply1 and supply0, as a static complementary CMOS XOR.
  - Input inverters generate x_n and y_n.
  - The pull-up and pull-down networks are complementary, so the output is never floating or fought for any 0/1 input combination.
REQ-013 a_n SHALL be driven by a CMOS inverter (one pmos, one nmos) on a.
REQ-014 For any 0/1 input, a and a_n SHALL be strong 0/1 and never X or Z.
REQ-015 An X or Z on x or y MAY produce X on a and a_n, and SHALL NOT affect ones_cnt or a_q beyond the cycle in which it is sampled.
REQ-016 On each rising clk edge with rst low, a_q SHALL take the value of a, giving one cycle of latency.
REQ-017 On each rising clk edge with rst low and a == 1, ones_cnt SHALL increment by 1.
REQ-018 ones_cnt SHALL saturate at 2^CNT_W-1: when at maximum, it holds and does not wrap to 0.
REQ-019 With a == 0 at the edge, ones_cnt SHALL hold its value.
REQ-020 Input changes between clock edges SHALL affect a and a_n immediately, and a_q and ones_cnt only at the next rising edge.

Reset
REQ-021 While rst is high, a_q SHALL be 0 and ones_cnt SHALL be 0, taking effect immediately without waiting for clk.
REQ-022 Reset SHALL NOT affect a or a_n; they continue to follow x and y during reset.
REQ-023 Reset asserted mid-count SHALL clear ones_cnt to 0 asynchronously.
REQ-024 Counting SHALL resume from 0 at the first rising edge after rst deasserts.
REQ-025 If rst deasserts coincident with a rising edge, that edge SHALL NOT update a_q or ones_cnt.

Verification
REQ-026 Truth table: apply x,y = 00, 01, 10, 11 at 10 ns intervals, clock idle -> a = 0, 1, 1, 0 and a_n = 1, 0, 0, 1, each within the same time step.
REQ-027 Registered path: rst released, x=1, y=0 held for 3 edges -> a_q=1 after the first edge and ones_cnt=3; then set x=1, y=1 -> a_q=0 after the next edge and ones_cnt stays 3.
REQ-028 Saturation: CNT_W=4, x=0, y=1 for 20 edges -> ones_cnt reaches 15 after edge 15 and remains 15 through edge 20.
REQ-029 Async reset: ones_cnt=5 and a_q=1, assert rst between edges -> a_q=0 and ones_cnt=0 immediately, while a still equals x XOR y.
REQ-030 Reset release: deassert rst with x=1, y=0 -> ones_cnt=1 and a_q=1 after the first subsequent rising edge.
REQ-031 Mid-cycle glitch: toggle x 0->1->0 between edges with y=0 -> a pulses 0->1->0, while a_q and ones_cnt are unchanged at the next edge.
